// File: rtl/seq_chunk_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_chunk_adder_if
// Purpose  : Operand/result bundle for seq_chunk_adder. It carries the
//            start/busy/done handshake, the operands and the result flags.
// Ports    : master -> drives start, a, b, cin, sub; observes busy, done,
//                      sum, cout, ovf
//            slave  -> the adder side of the same signals
// Revision : 1.0  initial release
// ============================================================================
interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/seq_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : seq_chunk_adder
// Purpose  : Multi-cycle adder/subtractor. It processes a WIDTH-bit operation
//            one CHUNK-bit slice per clock, LSB slice first. A CHUNK-bit
//            ripple adder is used, and the carry is registered between slices.
// Ports    : clk    rising-edge clock
//            rst_n  asynchronous active-low reset
//            bus    seq_chunk_adder_if.slave:
//                     start/a/b/cin/sub in, busy/done/sum/cout/ovf out
// Revision : 1.0  initial release
// ============================================================================
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  seq_chunk_adder_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;

  // The operands shift right one slice per RUN edge. The active slice is
  // therefore always at bits [CHUNK-1:0]. No variable part-select is needed.
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_c;
  logic [WIDTH-1:0]   r_work;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic               w_accept;
  logic               w_last;
  logic [CHUNK:0]     w_slice;
  logic [WIDTH+CHUNK-1:0] w_cat;
  logic [WIDTH-1:0]   w_work_next;
  logic               w_c_msb;

  // A start request is taken only when no operation is in flight.
  assign w_accept = bus.start && (r_state != RUN);
  assign w_last   = (r_state == RUN) && (r_cnt == C_LAST);

  assign w_slice  = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, r_c};

  // New result slices enter at the top. After NCHUNK shifts, slice 0 has
  // reached the bottom.
  assign w_cat       = {w_slice[CHUNK-1:0], r_work} >> CHUNK;
  assign w_work_next = w_cat[WIDTH-1:0];

  // The carry into the top bit of the slice is recovered from the sum bit.
  // On the last slice, this top bit is the MSB of the whole result.
  assign w_c_msb = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_slice[CHUNK-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    w_next = bus.start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= 1'b0;
      r_work <= '0;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is performed as a + ~b + 1, so B is inverted at capture.
      r_a    <= bus.a;
      r_b    <= bus.sub ? ~bus.b : bus.b;
      r_c    <= bus.sub | bus.cin;
      r_work <= '0;
      r_cnt  <= '0;
    end else if (r_state == RUN) begin
      r_a    <= r_a >> CHUNK;
      r_b    <= r_b >> CHUNK;
      r_c    <= w_slice[CHUNK];
      r_work <= w_work_next;
      r_cnt  <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_sum  <= w_work_next;
        r_cout <= w_slice[CHUNK];
        r_ovf  <= w_c_msb ^ w_slice[CHUNK];
      end
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;

endmodule
`default_nettype wire
